id_stage_hz: RTL



---
 rtl/id_pkg.sv | 69 ++++++
 rtl/id_stage_hz_if.sv | 28 ++
 rtl/id_decoder.sv | 96 +++++++++
 rtl/id_stage_hz.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode constants and types for the MIPS ID stage: opcodes, op enum,
// T_use/T_new encodings and the decoder result record.
package id_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADDU = 4'd1,
    OP_SUBU = 4'd2,
    OP_ORI  = 4'd3,
    OP_LUI  = 4'd4,
    OP_SLL  = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_BNE  = 4'd9,
    OP_J    = 4'd10,
    OP_JAL  = 4'd11,
    OP_JR   = 4'd12
  } op_e;

  // T_use values; TUSE_INF marks an operand the instruction never reads.
  localparam int TUSE_W = 2;
  localparam logic [TUSE_W-1:0] TUSE_0   = 2'd0;
  localparam logic [TUSE_W-1:0] TUSE_1   = 2'd1;
  localparam logic [TUSE_W-1:0] TUSE_2   = 2'd2;
  localparam logic [TUSE_W-1:0] TUSE_INF = 2'd3;

  localparam int DEC_TNEW_W = 2;
  localparam logic [DEC_TNEW_W-1:0] TNEW_0 = 2'd0;
  localparam logic [DEC_TNEW_W-1:0] TNEW_1 = 2'd1;
  localparam logic [DEC_TNEW_W-1:0] TNEW_2 = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    EXT_SIGN  = 3'd0,
    EXT_ZERO  = 3'd1,
    EXT_LUI   = 3'd2,
    EXT_SHAMT = 3'd3,
    EXT_PC8   = 3'd4
  } ext_e;

  typedef struct packed {
    op_e                   op;
    logic [4:0]            wa;
    logic [DEC_TNEW_W-1:0] tnew;
    logic [TUSE_W-1:0]     tuse_rs;
    logic [TUSE_W-1:0]     tuse_rt;
    ext_e                  ext;
  } dec_t;

endpackage

// File: rtl/id_stage_hz_if.sv
// ID/EX pipeline register bundle: the ID stage drives it, EX consumes it.
interface id_stage_hz_if #(
  parameter int XLEN   = 32,
  parameter int TNEW_W = 2
);
  import id_pkg::*;

  op_e               idex_op_o;
  logic [4:0]        idex_rs_o;
  logic [4:0]        idex_rt_o;
  logic [4:0]        idex_wa_o;
  logic [XLEN-1:0]   idex_rsdata_o;
  logic [XLEN-1:0]   idex_rtdata_o;
  logic [XLEN-1:0]   idex_imm_o;
  logic [XLEN-1:0]   idex_pc_o;
  logic [TNEW_W-1:0] idex_tnew_o;

  modport master (
    output idex_op_o, idex_rs_o, idex_rt_o, idex_wa_o, idex_rsdata_o,
           idex_rtdata_o, idex_imm_o, idex_pc_o, idex_tnew_o
  );

  modport slave (
    input  idex_op_o, idex_rs_o, idex_rt_o, idex_wa_o, idex_rsdata_o,
           idex_rtdata_o, idex_imm_o, idex_pc_o, idex_tnew_o
  );

endinterface

// File: rtl/id_decoder.sv
// Combinational instruction decoder: op, destination, T_new, T_use per operand
// and immediate extension mode. Unsupported encodings fall through to NOP.
module id_decoder
  import id_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0] opc;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opc   = instr_i[31:26];
  assign funct = instr_i[5:0];
  assign rt    = instr_i[20:16];
  assign rd    = instr_i[15:11];

  always_comb begin
    dec_o.op      = OP_NOP;
    dec_o.wa      = 5'd0;
    dec_o.tnew    = TNEW_0;
    dec_o.tuse_rs = TUSE_INF;
    dec_o.tuse_rt = TUSE_INF;
    dec_o.ext     = EXT_SIGN;
    if (instr_i != NOP_INSTR) begin
      case (opc)
        OPC_RTYPE: begin
          case (funct)
            FN_ADDU, FN_SUBU: begin
              dec_o.op      = (funct == FN_ADDU) ? OP_ADDU : OP_SUBU;
              dec_o.wa      = rd;
              dec_o.tnew    = TNEW_1;
              dec_o.tuse_rs = TUSE_1;
              dec_o.tuse_rt = TUSE_1;
            end
            FN_SLL: begin
              dec_o.op      = OP_SLL;
              dec_o.wa      = rd;
              dec_o.tnew    = TNEW_1;
              dec_o.tuse_rt = TUSE_1;
              dec_o.ext     = EXT_SHAMT;
            end
            FN_JR: begin
              dec_o.op      = OP_JR;
              dec_o.tuse_rs = TUSE_0;
            end
            default: ;
          endcase
        end
        OPC_ORI: begin
          dec_o.op      = OP_ORI;
          dec_o.wa      = rt;
          dec_o.tnew    = TNEW_1;
          dec_o.tuse_rs = TUSE_1;
          dec_o.ext     = EXT_ZERO;
        end
        OPC_LUI: begin
          dec_o.op   = OP_LUI;
          dec_o.wa   = rt;
          dec_o.tnew = TNEW_1;
          dec_o.ext  = EXT_LUI;
        end
        OPC_LW: begin
          dec_o.op      = OP_LW;
          dec_o.wa      = rt;
          dec_o.tnew    = TNEW_2;
          dec_o.tuse_rs = TUSE_1;
        end
        OPC_SW: begin
          // Store data is only needed in MEM, so rt tolerates a later producer.
          dec_o.op      = OP_SW;
          dec_o.tuse_rs = TUSE_1;
          dec_o.tuse_rt = TUSE_2;
        end
        OPC_BEQ, OPC_BNE: begin
          dec_o.op      = (opc == OPC_BEQ) ? OP_BEQ : OP_BNE;
          dec_o.tuse_rs = TUSE_0;
          dec_o.tuse_rt = TUSE_0;
        end
        OPC_J: begin
          dec_o.op = OP_J;
        end
        OPC_JAL: begin
          dec_o.op   = OP_JAL;
          dec_o.wa   = 5'd31;
          dec_o.tnew = TNEW_0;
          dec_o.ext  = EXT_PC8;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/id_stage_hz.sv
// MIPS decode stage: operand forwarding from EX/MEM, T_use/T_new hazard stall,
// branch/jump resolution and the ID/EX pipeline register with bubble and hold.
module id_stage_hz
  import id_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TNEW_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic [4:0]        grf_rs_addr_o,
  output logic [4:0]        grf_rt_addr_o,
  input  logic [XLEN-1:0]   grf_rs_data_i,
  input  logic [XLEN-1:0]   grf_rt_data_i,
  input  logic [4:0]        ex_wa_i,
  input  logic [TNEW_W-1:0] ex_tnew_i,
  input  logic [XLEN-1:0]   ex_wdata_i,
  input  logic [4:0]        mem_wa_i,
  input  logic [TNEW_W-1:0] mem_tnew_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic              npc_sel_o,
  output logic [XLEN-1:0]   npc_o,
  id_stage_hz_if.master     idex_o
);

  localparam int CW = (TNEW_W > TUSE_W) ? TNEW_W : TUSE_W;

  dec_t            dec;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [15:0]     imm16;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rs_fwd;
  logic [XLEN-1:0] rt_fwd;
  logic            haz_rs;
  logic            haz_rt;
  logic            hazard;
  logic            taken;

  id_decoder u_dec (
    .instr_i (instr_i),
    .dec_o   (dec)
  );

  assign rs            = instr_i[25:21];
  assign rt            = instr_i[20:16];
  assign imm16         = instr_i[15:0];
  assign grf_rs_addr_o = rs;
  assign grf_rt_addr_o = rt;
  assign imm_sext      = {{(XLEN-16){imm16[15]}}, imm16};
  assign pc_plus4      = pc_i + XLEN'(4);

  // Stall when a producer's result arrives later than this operand is needed.
  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    if (dec.tuse_rs != TUSE_INF && rs != 5'd0) begin
      haz_rs = (ex_wa_i == rs && CW'(ex_tnew_i) > CW'(dec.tuse_rs)) ||
               (mem_wa_i == rs && CW'(mem_tnew_i) > CW'(dec.tuse_rs));
    end
    if (dec.tuse_rt != TUSE_INF && rt != 5'd0) begin
      haz_rt = (ex_wa_i == rt && CW'(ex_tnew_i) > CW'(dec.tuse_rt)) ||
               (mem_wa_i == rt && CW'(mem_tnew_i) > CW'(dec.tuse_rt));
    end
  end

  assign hazard  = haz_rs || haz_rt;
  assign stall_o = hazard || hold_i;

  // Later assignments win, so EX overrides MEM overrides GRF.
  always_comb begin
    rs_fwd = grf_rs_data_i;
    rt_fwd = grf_rt_data_i;
    if (rs != 5'd0 && mem_wa_i == rs && mem_tnew_i == '0) rs_fwd = mem_wdata_i;
    if (rs != 5'd0 && ex_wa_i == rs && ex_tnew_i == '0)   rs_fwd = ex_wdata_i;
    if (rt != 5'd0 && mem_wa_i == rt && mem_tnew_i == '0) rt_fwd = mem_wdata_i;
    if (rt != 5'd0 && ex_wa_i == rt && ex_tnew_i == '0)   rt_fwd = ex_wdata_i;
  end

  always_comb begin
    imm_ext = imm_sext;
    case (dec.ext)
      EXT_ZERO:  imm_ext = {{(XLEN-16){1'b0}}, imm16};
      EXT_LUI:   imm_ext = {{(XLEN-32){1'b0}}, imm16, 16'h0000};
      EXT_SHAMT: imm_ext = {{(XLEN-5){1'b0}}, instr_i[10:6]};
      EXT_PC8:   imm_ext = pc_i + XLEN'(8);
      default:   imm_ext = imm_sext;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    npc_o = pc_plus4 + (imm_sext << 2);
    case (dec.op)
      OP_BEQ: taken = (rs_fwd == rt_fwd);
      OP_BNE: taken = (rs_fwd != rt_fwd);
      OP_J, OP_JAL: begin
        taken = 1'b1;
        npc_o = {pc_plus4[XLEN-1:28], instr_i[25:0], 2'b00};
      end
      OP_JR: begin
        taken = 1'b1;
        npc_o = rs_fwd;
      end
      default: ;
    endcase
  end

  // The delay slot is always executed, so a redirect never flushes IF/ID.
  assign npc_sel_o = taken && !stall_o;

  op_e               op_q, op_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        wa_q, wa_d;
  logic [XLEN-1:0]   rsdata_q, rsdata_d;
  logic [XLEN-1:0]   rtdata_q, rtdata_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d;

  always_comb begin
    op_d     = op_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    wa_d     = wa_q;
    rsdata_d = rsdata_q;
    rtdata_d = rtdata_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    tnew_d   = tnew_q;
    if (hold_i) begin
      op_d = op_q;
    end else if (hazard) begin
      op_d     = OP_NOP;
      rs_d     = 5'd0;
      rt_d     = 5'd0;
      wa_d     = 5'd0;
      rsdata_d = '0;
      rtdata_d = '0;
      imm_d    = '0;
      pc_d     = pc_i;
      tnew_d   = '0;
    end else begin
      op_d     = dec.op;
      rs_d     = rs;
      rt_d     = rt;
      wa_d     = dec.wa;
      rsdata_d = rs_fwd;
      rtdata_d = rt_fwd;
      imm_d    = imm_ext;
      pc_d     = pc_i;
      tnew_d   = TNEW_W'(dec.tnew);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_NOP;
      rs_q     <= 5'd0;
      rt_q     <= 5'd0;
      wa_q     <= 5'd0;
      rsdata_q <= '0;
      rtdata_q <= '0;
      imm_q    <= '0;
      pc_q     <= XLEN'(RESET_PC);
      tnew_q   <= '0;
    end else begin
      op_q     <= op_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      wa_q     <= wa_d;
      rsdata_q <= rsdata_d;
      rtdata_q <= rtdata_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      tnew_q   <= tnew_d;
    end
  end

  assign idex_o.idex_op_o     = op_q;
  assign idex_o.idex_rs_o     = rs_q;
  assign idex_o.idex_rt_o     = rt_q;
  assign idex_o.idex_wa_o     = wa_q;
  assign idex_o.idex_rsdata_o = rsdata_q;
  assign idex_o.idex_rtdata_o = rtdata_q;
  assign idex_o.idex_imm_o    = imm_q;
  assign idex_o.idex_pc_o     = pc_q;
  assign idex_o.idex_tnew_o   = tnew_q;

endmodule
